// File: rtl/bpu_update_queue_pkg.sv
// Shared widths and the BpuUpdateInfo payload for the BPU update queue.
// Define BPU_UPD_COALESCE_EN to merge a request into the youngest entry when start_addr matches.
package bpu_update_queue_pkg;

  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 32;
  localparam int ENTRY_W  = 64;
  localparam int SLOT_NUM = 2;
  localparam int CNT_W    = 16;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int QCNT_W   = PTR_W + 1;

  typedef logic [ENTRY_W-1:0] btb_entry_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   start_addr;
    btb_entry_t          btb_entry;
    logic [SLOT_NUM-1:0] real_taken;
    logic [SLOT_NUM-1:0] meta_ctr;
  } bpu_update_info_t;

  localparam int INFO_W = $bits(bpu_update_info_t);

`ifdef BPU_UPD_COALESCE_EN
  localparam bit COALESCE_EN = 1'b1;
`else
  localparam bit COALESCE_EN = 1'b0;
`endif

endpackage

// File: rtl/bpu_update_queue_if.sv
// FSQ-commit and predictor-training signals of the BPU update queue.
interface bpu_update_queue_if;
  import bpu_update_queue_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_start_addr;
  btb_entry_t          in_btb_entry;
  logic [SLOT_NUM-1:0] in_real_taken;
  logic [SLOT_NUM-1:0] in_meta_ctr;
  logic                pred_stall;
  logic                update;
  logic [ADDR_W-1:0]   upd_start_addr;
  btb_entry_t          upd_btb_entry;
  logic [SLOT_NUM-1:0] upd_real_taken;
  logic [SLOT_NUM-1:0] upd_meta_ctr;
  logic                empty;
  logic [CNT_W-1:0]    issued_cnt;

  modport master (
    output in_valid, in_start_addr, in_btb_entry, in_real_taken, in_meta_ctr, pred_stall,
    input  in_ready, update, upd_start_addr, upd_btb_entry, upd_real_taken, upd_meta_ctr,
           empty, issued_cnt
  );

  modport slave (
    input  in_valid, in_start_addr, in_btb_entry, in_real_taken, in_meta_ctr, pred_stall,
    output in_ready, update, upd_start_addr, upd_btb_entry, upd_real_taken, upd_meta_ctr,
           empty, issued_cnt
  );

endinterface

// File: rtl/bpu_update_queue_upd_fifo.sv
// Generic DEPTH x W circular buffer; also exposes the youngest entry and an in-place overwrite of it.
module upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     ovr_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [W-1:0]             last_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, last_idx;
  logic [AW:0]   count_q, count_d;

  assign last_idx = tail_q - PTR_ONE;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i)  head_d = head_q + PTR_ONE;
    if (push_i) tail_d = tail_q + PTR_ONE;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: stale slots are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_i)     mem_q[tail_q]   <= wdata_i;
    else if (ovr_i) mem_q[last_idx] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign last_o  = mem_q[last_idx];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bpu_update_queue.sv
// Buffers resolved fetch-stream updates and issues one registered predictor update per free cycle.
// Optional BPU_UPD_COALESCE_EN (see package) merges same-address requests into the youngest entry.
module bpu_update_queue
  import bpu_update_queue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  bpu_update_queue_if.slave  bus
);

  bpu_update_info_t  in_info, head_info, last_info, upd_q, upd_d;
  logic [INFO_W-1:0] head_raw, last_raw;
  logic [QCNT_W-1:0] count;
  logic              full, empty;
  logic              issue, youngest_leaving, coalesce, in_ready, push, ovr;
  logic              update_q, update_d;
  logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;

  assign in_info   = '{start_addr: bus.in_start_addr, btb_entry: bus.in_btb_entry,
                       real_taken: bus.in_real_taken, meta_ctr: bus.in_meta_ctr};
  assign head_info = bpu_update_info_t'(head_raw);
  assign last_info = bpu_update_info_t'(last_raw);

  upd_fifo #(.DEPTH(DEPTH), .W(INFO_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (issue),
    .ovr_i   (ovr),
    .wdata_i (in_info),
    .rdata_o (head_raw),
    .last_o  (last_raw),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    issue            = !empty && !bus.pred_stall;
    youngest_leaving = issue && (count == QCNT_W'(1));
    // Merging into the entry that is leaving this cycle would lose the newer payload.
    coalesce         = COALESCE_EN && bus.in_valid && !empty && !youngest_leaving
                       && (last_info.start_addr == bus.in_start_addr);
    in_ready         = !full || coalesce;
    push             = bus.in_valid && !full && !coalesce;
    ovr              = bus.in_valid && coalesce;
    update_d         = issue;
    upd_d            = issue ? head_info : upd_q;
    issued_cnt_d     = issue ? issued_cnt_q + CNT_W'(1) : issued_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      update_q     <= 1'b0;
      upd_q        <= '0;
      issued_cnt_q <= '0;
    end else begin
      update_q     <= update_d;
      upd_q        <= upd_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.update         = update_q;
  assign bus.upd_start_addr = upd_q.start_addr;
  assign bus.upd_btb_entry  = upd_q.btb_entry;
  assign bus.upd_real_taken = upd_q.real_taken;
  assign bus.upd_meta_ctr   = upd_q.meta_ctr;
  assign bus.empty          = empty;
  assign bus.issued_cnt     = issued_cnt_q;

endmodule
